// File: rtl/cal_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cal_pipe_pkg
// Brief    : Shared types and helpers for the pipeline hazard control unit.
//            Holds the scoreboard entry layout and the sequencer state type.
// Revision : 1.0 - initial release
// ============================================================================
package cal_pipe_pkg;

    // Architectural zero register: writes to it are discarded, so it never
    // creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One in-flight writer tracked by the scoreboard.
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wb_en;
        logic       mem_r;
        logic       mem_acc;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // Sequencer states: normal flow, or waiting on data memory.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hc_state_t;

    // True when entry e will write register src and src is a real register.
    function automatic logic entry_match(input sb_entry_t e, input logic [4:0] src);
        return e.valid && e.wb_en && (e.dest == src) && (src != REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Shift register of in-flight writers ([0]=EXE, [1]=MEM, [2]=WB)
//            with per-entry source comparators. Returns one hit bit per entry
//            for each ID source operand, and flags a memory access in MEM.
//            Build option HAZARD_FWD_EN: only the EXE entry is compared, and
//            only when it is a load (load-use); otherwise every entry counts.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import cal_pipe_pkg::*;
#(
    parameter int SB_DEPTH = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                shift_en_i,
    input  sb_entry_t           new_entry_i,
    input  logic [4:0]          src1_i,
    input  logic [4:0]          src2_i,
    output logic [SB_DEPTH-1:0] hit1_o,
    output logic [SB_DEPTH-1:0] hit2_o,
    output logic                mem_busy_o
);

    sb_entry_t [SB_DEPTH-1:0] sb_q;
    sb_entry_t [SB_DEPTH-1:0] sb_d;

    // Advance one stage per cycle; hold everything while the pipe is frozen.
    always_comb begin
        sb_d = sb_q;
        if (shift_en_i) begin
            sb_d[0] = new_entry_i;
            for (int i = 1; i < SB_DEPTH; i++) begin
                sb_d[i] = sb_q[i-1];
            end
        end
    end

    // Scoreboard storage; reset drops every in-flight writer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_q[i] <= SB_EMPTY;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    // Per-entry comparators. With forwarding only a load sitting in EXE can
    // not be bypassed in time; later stages are covered by the forward paths.
    for (genvar i = 0; i < SB_DEPTH; i++) begin : g_cmp
`ifdef HAZARD_FWD_EN
        if (i == 0) begin : g_load_use
            assign hit1_o[i] = entry_match(sb_q[i], src1_i) & sb_q[i].mem_r;
            assign hit2_o[i] = entry_match(sb_q[i], src2_i) & sb_q[i].mem_r;
        end else begin : g_forwarded
            assign hit1_o[i] = 1'b0;
            assign hit2_o[i] = 1'b0;
        end
`else
        assign hit1_o[i] = entry_match(sb_q[i], src1_i);
        assign hit2_o[i] = entry_match(sb_q[i], src2_i);
`endif
    end

    // The MEM entry is the one whose data access can stall the whole pipe.
    assign mem_busy_o = sb_q[1].valid & sb_q[1].mem_acc;

    // Fields of the oldest entry leave the pipe without further use.
    logic sb_unused;
    assign sb_unused = ^sb_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Brief    : Pipeline sequencer beside the ID stage. Detects RAW / load-use
//            hazards against a writer scoreboard, freezes the pipe while data
//            memory is busy, gates the branch flush, raises a sticky memory
//            timeout and counts stall cycles.
//            Build option HAZARD_FWD_EN: forwarding present, only load-use
//            hazards on the EXE entry stall (handled in hazard_scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
    import cal_pipe_pkg::*;
#(
    parameter int SB_DEPTH    = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid_i,
    input  logic [4:0]  src1_i,
    input  logic [4:0]  src2_i,
    input  logic        src2_used_i,
    input  logic [4:0]  id_dest_i,
    input  logic        id_wb_en_i,
    input  logic        id_mem_r_en_i,
    input  logic        id_mem_w_en_i,
    input  logic        br_taken_i,
    input  logic        mem_ready_i,
    output logic        hazard_stall_o,
    output logic        id_bubble_o,
    output logic        if_flush_o,
    output logic        pipe_freeze_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cycles_o
);

    localparam logic [7:0]  TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [31:0] STALL_MAX   = 32'hFFFF_FFFF;

    logic [SB_DEPTH-1:0] hit1;
    logic [SB_DEPTH-1:0] hit2;
    logic                mem_busy;
    logic                hit;
    logic                pipe_freeze;
    logic                hazard_stall;
    logic                if_flush;
    sb_entry_t           new_entry;

    hc_state_t   state_q,        state_d;
    logic [7:0]  wait_cnt_q,     wait_cnt_d;
    logic        mem_timeout_q,  mem_timeout_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    hazard_scoreboard #(
        .SB_DEPTH    (SB_DEPTH)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .shift_en_i  (~pipe_freeze),
        .new_entry_i (new_entry),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .hit1_o      (hit1),
        .hit2_o      (hit2),
        .mem_busy_o  (mem_busy)
    );

    // Pipe control decode. A freeze overrides a hazard, and either one
    // suppresses the branch flush so the branch re-resolves once released.
    // Everything is forced low while reset is asserted.
    always_comb begin
        hit          = id_valid_i & ((|hit1) | (src2_used_i & (|hit2)));
        pipe_freeze  = rst_ni & mem_busy & ~mem_ready_i;
        hazard_stall = rst_ni & hit & ~pipe_freeze;
        if_flush     = rst_ni & br_taken_i & id_valid_i & ~hazard_stall & ~pipe_freeze;
    end

    // Instruction leaving ID: a stalled or empty slot enters as a bubble,
    // while a taken branch still enters as a normal entry.
    always_comb begin
        new_entry         = SB_EMPTY;
        new_entry.valid   = id_valid_i & ~hazard_stall;
        new_entry.dest    = id_dest_i;
        new_entry.wb_en   = id_wb_en_i;
        new_entry.mem_r   = id_mem_r_en_i;
        new_entry.mem_acc = id_mem_r_en_i | id_mem_w_en_i;
    end

    // Memory wait tracking: count cycles spent waiting; once the count has
    // reached the limit the error flag latches and the count holds.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        unique case (state_q)
            RUN: begin
                wait_cnt_d = 8'd0;
                if (pipe_freeze) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_q == TIMEOUT_VAL) begin
                    mem_timeout_d = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q != TIMEOUT_VAL) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Saturating performance counter of cycles lost to stalls or freezes.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((hazard_stall | pipe_freeze) && (stall_cycles_q != STALL_MAX)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Sequencer and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hazard_stall_o = hazard_stall;
    assign id_bubble_o    = hazard_stall;
    assign if_flush_o     = if_flush;
    assign pipe_freeze_o  = pipe_freeze;
    assign mem_timeout_o  = mem_timeout_q;
    assign stall_cycles_o = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_unit
// Brief    : Self-checking bench for hazard_ctrl_unit (vector table, freeze
//            and reset sequences, randomized run against a reference model).
//            Expectations follow HAZARD_FWD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_ctrl_unit;

    localparam int SB_DEPTH    = 3;
    localparam int MEM_TIMEOUT = 3;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, src2_used, id_wb_en, id_mem_r_en, id_mem_w_en;
    logic        br_taken, mem_ready;
    logic [4:0]  src1, src2, id_dest;
    logic        hazard_stall, id_bubble, if_flush, pipe_freeze, mem_timeout;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .SB_DEPTH       (SB_DEPTH),
        .MEM_TIMEOUT    (MEM_TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .id_valid_i     (id_valid),
        .src1_i         (src1),
        .src2_i         (src2),
        .src2_used_i    (src2_used),
        .id_dest_i      (id_dest),
        .id_wb_en_i     (id_wb_en),
        .id_mem_r_en_i  (id_mem_r_en),
        .id_mem_w_en_i  (id_mem_w_en),
        .br_taken_i     (br_taken),
        .mem_ready_i    (mem_ready),
        .hazard_stall_o (hazard_stall),
        .id_bubble_o    (id_bubble),
        .if_flush_o     (if_flush),
        .pipe_freeze_o  (pipe_freeze),
        .mem_timeout_o  (mem_timeout),
        .stall_cycles_o (stall_cycles)
    );

    typedef struct {
        logic       v;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       s2u;
        logic [4:0] d;
        logic       wb, mr, mw, br, rdy;
    } in_t;

    typedef struct {
        in_t  i;
        logic stall_nf, flush_nf, stall_fw, flush_fw;
    } vec_t;

    typedef struct {
        logic       v;
        logic [4:0] d;
        logic       wb, mr, ma;
    } ment_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                               input logic s2u, input logic [4:0] d, input logic wb,
                               input logic mr, input logic mw, input logic br, input logic rdy);
        in_t x;
        x.v = v; x.s1 = s1; x.s2 = s2; x.s2u = s2u; x.d = d;
        x.wb = wb; x.mr = mr; x.mw = mw; x.br = br; x.rdy = rdy;
        return x;
    endfunction

    function automatic vec_t mv(input in_t i, input logic snf, input logic fnf,
                                input logic sfw, input logic ffw);
        vec_t r;
        r.i = i; r.stall_nf = snf; r.flush_nf = fnf; r.stall_fw = sfw; r.flush_fw = ffw;
        return r;
    endfunction

    task automatic drive(input in_t x);
        id_valid    = x.v;   src1     = x.s1;  src2        = x.s2;
        src2_used   = x.s2u; id_dest  = x.d;   id_wb_en    = x.wb;
        id_mem_r_en = x.mr;  id_mem_w_en = x.mw; br_taken  = x.br;
        mem_ready   = x.rdy;
    endtask

    // Drive on the falling edge, settle, leave time for comb checks.
    task automatic apply(input in_t x);
        @(negedge clk);
        drive(x);
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_comb(input string tag, input logic st, input logic fl, input logic fz);
        chk({tag, ".stall"},  {31'd0, hazard_stall}, {31'd0, st});
        chk({tag, ".bubble"}, {31'd0, id_bubble},    {31'd0, st});
        chk({tag, ".flush"},  {31'd0, if_flush},     {31'd0, fl});
        chk({tag, ".freeze"}, {31'd0, pipe_freeze},  {31'd0, fz});
    endtask

    // Load in MEM waits n cycles for memory, a reader of the load target
    // stays in ID throughout, then memory completes.
    task automatic freeze_episode(input int n);
        in_t ld, xi, rd;
        ld = mk(1, 1, 2, 0, 3, 1, 1, 0, 0, 1);
        xi = mk(1, 1, 2, 0, 4, 1, 0, 0, 0, 1);
        rd = mk(1, 3, 0, 0, 7, 1, 0, 0, 1, 0);
        do_reset();
        apply(ld); chk_comb($sformatf("frz%0d.ld", n), 0, 0, 0);
        apply(xi); chk_comb($sformatf("frz%0d.x", n), 0, 0, 0);
        for (int k = 0; k < n; k++) begin
            apply(rd);
            chk_comb($sformatf("frz%0d.c%0d", n, k), 0, 0, 1);
            after_edge();
            chk($sformatf("frz%0d.c%0d.timeout", n, k), {31'd0, mem_timeout},
                {31'd0, (k >= MEM_TIMEOUT + 1)});
        end
        rd.rdy = 1'b1;
        apply(rd);
        chk_comb($sformatf("frz%0d.release", n), FWD ? 1'b0 : 1'b1, FWD ? 1'b1 : 1'b0, 0);
        after_edge();
        chk($sformatf("frz%0d.timeout", n), {31'd0, mem_timeout}, {31'd0, (n >= MEM_TIMEOUT + 1)});
        chk($sformatf("frz%0d.stall_cycles", n), stall_cycles, 32'(n + (FWD ? 0 : 1)));
        rd.rdy = 1'b0;
        apply(rd);
        chk($sformatf("frz%0d.after.freeze", n), {31'd0, pipe_freeze}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[$];
        in_t   rd;
        ment_t m_sb[SB_DEPTH];
        logic [31:0] m_stalls;
        bit    m_to;
        int    m_run;

        rst_n = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // ---------------- reset state ----------------
        do_reset();
        #1;
        chk_comb("reset", 0, 0, 0);
        chk("reset.timeout", {31'd0, mem_timeout}, 32'd0);
        chk("reset.stall_cycles", stall_cycles, 32'd0);

        // ---------------- vector table ----------------
        //                   v  s1 s2 u  d wb mr mw br rdy      nf:st fl  fw:st fl
        tbl.push_back(mv(mk(1,  1, 2, 1, 5, 1, 0, 0, 0, 1), 0, 0, 0, 0));
        tbl.push_back(mv(mk(1,  5, 0, 1, 6, 1, 0, 0, 0, 1), 1, 0, 0, 0));
        tbl.push_back(mv(mk(1,  5, 0, 1, 6, 1, 0, 0, 0, 1), 1, 0, 0, 0));
        tbl.push_back(mv(mk(1,  5, 0, 1, 6, 1, 0, 0, 0, 1), 1, 0, 0, 0));
        tbl.push_back(mv(mk(1,  5, 0, 1, 6, 1, 0, 0, 0, 1), 0, 0, 0, 0));
        tbl.push_back(mv(mk(1,  7, 8, 1, 0, 1, 1, 0, 0, 1), 0, 0, 0, 0));
        tbl.push_back(mv(mk(1,  0, 0, 1, 9, 1, 1, 0, 0, 1), 0, 0, 0, 0));
        tbl.push_back(mv(mk(1, 10, 9, 0,11, 1, 0, 0, 0, 1), 0, 0, 0, 0));
        tbl.push_back(mv(mk(1, 10, 9, 1,11, 1, 0, 0, 0, 1), 1, 0, 0, 0));
        tbl.push_back(mv(mk(1, 10, 9, 1,11, 1, 0, 0, 0, 1), 1, 0, 0, 0));
        tbl.push_back(mv(mk(1, 10, 9, 1,11, 1, 0, 0, 0, 1), 0, 0, 0, 0));
        tbl.push_back(mv(mk(1,  1, 0, 0,12, 1, 1, 0, 0, 1), 0, 0, 0, 0));
        tbl.push_back(mv(mk(1, 12, 0, 0, 0, 0, 0, 0, 1, 1), 1, 0, 1, 0));
        tbl.push_back(mv(mk(1, 12, 0, 0, 0, 0, 0, 0, 1, 1), 1, 0, 0, 1));
        tbl.push_back(mv(mk(1, 12, 0, 0, 0, 0, 0, 0, 1, 1), 1, 0, 0, 1));
        tbl.push_back(mv(mk(1, 12, 0, 0, 0, 0, 0, 0, 1, 1), 0, 1, 0, 1));
        tbl.push_back(mv(mk(0, 12, 0, 0, 0, 0, 0, 0, 1, 1), 0, 0, 0, 0));
        tbl.push_back(mv(mk(1, 12,12, 1, 0, 0, 0, 1, 0, 1), 0, 0, 0, 0));

        do_reset();
        foreach (tbl[r]) begin
            apply(tbl[r].i);
            chk_comb($sformatf("tbl%0d", r),
                     FWD ? tbl[r].stall_fw : tbl[r].stall_nf,
                     FWD ? tbl[r].flush_fw : tbl[r].flush_nf, 0);
        end
        after_edge();
        chk("tbl.stall_cycles", stall_cycles, FWD ? 32'd1 : 32'd8);

        // ---------------- memory freeze / timeout ----------------
        freeze_episode(3);
        freeze_episode(4);

        // ---------------- asynchronous reset while waiting ----------------
        do_reset();
        apply(mk(1, 1, 2, 0, 3, 1, 1, 0, 0, 1));
        apply(mk(1, 1, 2, 0, 4, 1, 0, 0, 0, 1));
        rd = mk(1, 3, 0, 0, 7, 1, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            apply(rd);
            after_edge();
        end
        chk("rstw.timeout_set", {31'd0, mem_timeout}, 32'd1);
        chk("rstw.freeze_before", {31'd0, pipe_freeze}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_comb("rstw.async", 0, 0, 0);
        chk("rstw.async.timeout", {31'd0, mem_timeout}, 32'd0);
        chk("rstw.async.stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_comb("rstw.release", 0, 1, 0);
        after_edge();
        chk("rstw.release.timeout", {31'd0, mem_timeout}, 32'd0);
        chk("rstw.release.stall_cycles", stall_cycles, 32'd0);

        // ---------------- randomized run against reference model ----------------
        do_reset();
        for (int k = 0; k < SB_DEPTH; k++) m_sb[k] = '{v: 0, d: 0, wb: 0, mr: 0, ma: 0};
        m_stalls = 32'd0;
        m_to     = 1'b0;
        m_run    = 0;
        for (int c = 0; c < 600; c++) begin
            in_t x;
            bit  hit, frz, stl, fl, look;
            x.v   = ($urandom_range(0, 7) != 0);
            x.s1  = 5'($urandom_range(0, 3));
            x.s2  = 5'($urandom_range(0, 3));
            x.s2u = ($urandom_range(0, 1) != 0);
            x.d   = 5'($urandom_range(0, 3));
            x.wb  = ($urandom_range(0, 3) != 0);
            x.mr  = ($urandom_range(0, 2) == 0);
            x.mw  = ($urandom_range(0, 3) == 0);
            x.br  = ($urandom_range(0, 3) == 0);
            x.rdy = ($urandom_range(0, 3) != 0);
            apply(x);

            hit = 1'b0;
            for (int k = 0; k < SB_DEPTH; k++) begin
                look = FWD ? (k == 0 && m_sb[k].mr) : 1'b1;
                if (look && m_sb[k].v && m_sb[k].wb && m_sb[k].d != 5'd0) begin
                    if (m_sb[k].d == x.s1) hit = 1'b1;
                    if (x.s2u && m_sb[k].d == x.s2) hit = 1'b1;
                end
            end
            hit = hit && x.v;
            frz = m_sb[1].v && m_sb[1].ma && !x.rdy;
            stl = hit && !frz;
            fl  = x.br && x.v && !stl && !frz;
            chk_comb($sformatf("rnd%0d", c), stl, fl, frz);

            if (!frz) begin
                for (int k = SB_DEPTH - 1; k > 0; k--) m_sb[k] = m_sb[k-1];
                m_sb[0] = '{v: x.v && !stl, d: x.d, wb: x.wb, mr: x.mr, ma: x.mr || x.mw};
            end
            if (m_run >= MEM_TIMEOUT + 1) m_to = 1'b1;
            m_run = frz ? m_run + 1 : 0;
            if ((stl || frz) && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;

            after_edge();
            chk($sformatf("rnd%0d.timeout", c), {31'd0, mem_timeout}, {31'd0, m_to});
            chk($sformatf("rnd%0d.stall_cycles", c), stall_cycles, m_stalls);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
